// File: rtl/alu_resp.sv
// Handshaked 4-bit ALU responder: computes add/sub/or/xor with carry and zero
// flags at request acceptance and returns responses in order through a 2-entry queue.
module alu_resp #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out,
  output logic       cf,
  output logic       zf,
  output logic [7:0] txn_cnt
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;

  logic [3:0] out_mem_reg [DEPTH];
  logic       cf_mem_reg  [DEPTH];
  logic       zf_mem_reg  [DEPTH];

  logic       wr_ptr_reg, wr_ptr_next;
  logic       rd_ptr_reg, rd_ptr_next;
  logic [1:0] count_reg, count_next;
  logic [7:0] txn_cnt_reg, txn_cnt_next;

  logic       push, pop;
  logic [4:0] sum, diff;
  logic [3:0] res_next;
  logic       cf_next, zf_next;

  // Both widened operations carry their flag in bit 4: carry for add, borrow for sub.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_next = 4'd0;
    cf_next  = 1'b0;
    case (op)
      OP_ADD: begin
        res_next = sum[3:0];
        cf_next  = sum[4];
      end
      OP_SUB: begin
        res_next = diff[3:0];
        cf_next  = diff[4];
      end
      OP_OR:   res_next = a | b;
      default: res_next = a ^ b;
    endcase
    zf_next = (res_next == 4'd0);
  end

  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  // A full queue can still take a request when the head leaves in the same edge.
  assign in_ready  = (count_reg < 2'd2) || pop;
  assign push      = in_valid && in_ready;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    txn_cnt_next = txn_cnt_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next  = rd_ptr_reg + 1'b1;
      txn_cnt_next = txn_cnt_reg + 8'd1;
    end
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
      txn_cnt_reg <= 8'd0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      txn_cnt_reg <= txn_cnt_next;
    end
  end

  // Storage is cleared on reset so the head reads as all-zero while empty.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          out_mem_reg[gi] <= 4'd0;
          cf_mem_reg[gi]  <= 1'b0;
          zf_mem_reg[gi]  <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          out_mem_reg[gi] <= res_next;
          cf_mem_reg[gi]  <= cf_next;
          zf_mem_reg[gi]  <= zf_next;
        end
      end
    end
  endgenerate

  assign out     = out_mem_reg[rd_ptr_reg];
  assign cf      = cf_mem_reg[rd_ptr_reg];
  assign zf      = zf_mem_reg[rd_ptr_reg];
  assign txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_alu_resp.sv
// Scoreboard bench for alu_resp: the driver queues hand-computed responses on
// acceptance, and a negedge monitor pops and compares each response handed over.
module tb_alu_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out;
  logic       cf, zf;
  logic [7:0] txn_cnt;

  typedef struct {
    logic [3:0] o;
    logic       c;
    logic       z;
  } resp_t;

  resp_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_txn = 8'd0;
  int         waited;

  alu_resp #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cf(cf), .zf(zf), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", {24'd0, out, 3'd0, cf, zf}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("resp", {20'd0, out, 3'd0, cf, 3'd0, zf}, {20'd0, e.o, 3'd0, e.c, 3'd0, e.z});
        check("txn_cnt_at_pop", {24'd0, txn_cnt}, {24'd0, exp_txn});
        $display("resp out=%0d cf=%0d zf=%0d txn_cnt=%0d", out, cf, zf, txn_cnt);
      end
      exp_txn = exp_txn + 8'd1;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the request.
  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top,
                      input logic [3:0] eo, input logic ec, input logic ez);
    resp_t e;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    op = top;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    e.o = eo;
    e.c = ec;
    e.z = ez;
    exp_q.push_back(e);
    $display("req a=%0d b=%0d op=%0d exp out=%0d cf=%0d zf=%0d", ta, tb, top, eo, ec, ez);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] want_txn);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    check("txn_cnt", {24'd0, txn_cnt}, {24'd0, want_txn});
    check("empty_after_drain", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_txn = 8'd0;
  endtask

  logic [3:0] tab_a  [10] = '{4'd1, 4'd8, 4'd9, 4'd0, 4'd12, 4'd6, 4'd7, 4'd14, 4'd5, 4'd0};
  logic [3:0] tab_b  [10] = '{4'd2, 4'd8, 4'd4, 4'd1, 4'd3,  4'd6, 4'd9, 4'd14, 4'd10, 4'd0};
  logic [1:0] tab_op [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2,  2'd3, 2'd0, 2'd1,  2'd3, 2'd2};
  logic [3:0] tab_o  [10] = '{4'd3, 4'd0, 4'd5, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd15, 4'd0};
  logic       tab_c  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0,  1'b0, 1'b0};
  logic       tab_z  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1,  1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lo;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 4'd0;
    b = 4'd0;
    op = 2'd0;
    do_reset();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_txn_cnt", {24'd0, txn_cnt}, 32'd0);
    check("rst_out_flags", {26'd0, out, cf, zf}, 32'd0);

    // Back-to-back ops on a=10, b=3
    out_ready = 1'b1;
    send(4'd10, 4'd3, 2'b00, 4'd13, 1'b0, 1'b0);
    check("latency_one_cycle", {31'd0, out_valid}, 32'd1);
    send(4'd10, 4'd3, 2'b01, 4'd7, 1'b0, 1'b0);
    send(4'd10, 4'd3, 2'b10, 4'd11, 1'b0, 1'b0);
    send(4'd10, 4'd3, 2'b11, 4'd9, 1'b0, 1'b0);
    idle();
    drain(8'd4);

    // Flag corner cases
    send(4'd15, 4'd1, 2'b00, 4'd0, 1'b1, 1'b1);
    send(4'd3, 4'd10, 2'b01, 4'd9, 1'b1, 1'b0);
    send(4'd5, 4'd5, 2'b11, 4'd0, 1'b0, 1'b1);
    idle();
    drain(8'd7);

    // Backpressure: fill, stall a third request, then release
    out_ready = 1'b0;
    send(4'd4, 4'd3, 2'b00, 4'd7, 1'b0, 1'b0);
    send(4'd9, 4'd9, 2'b11, 4'd0, 1'b0, 1'b1);
    in_valid = 1'b1;
    a = 4'd2;
    b = 4'd5;
    op = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("head_stable", {27'd0, out_valid, out}, {27'd0, 1'b1, 4'd7});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'd2, 4'd5, 2'b01, 4'd13, 1'b1, 1'b0);
    check("accept_in_pop_cycle", waited, 0);
    idle();
    drain(8'd10);

    // Sustained push+pop at count = 2
    out_ready = 1'b0;
    send(4'd1, 4'd1, 2'b00, 4'd2, 1'b0, 1'b0);
    send(4'd15, 4'd15, 2'b10, 4'd15, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tab_a[i], tab_b[i], tab_op[i], tab_o[i], tab_c[i], tab_z[i]);
      check("one_accept_per_cycle", waited, 0);
    end
    idle();
    drain(8'd22);

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lo = 4'(i);
      send(lo, 4'd0, 2'b10, lo, 1'b0, (lo == 4'd0));
    end
    idle();
    drain(8'd0);
    send(4'd6, 4'd2, 2'b00, 4'd8, 1'b0, 1'b0);
    idle();
    drain(8'd1);

    // Reset while full with a request pending
    out_ready = 1'b0;
    send(4'd3, 4'd4, 2'b00, 4'd7, 1'b0, 1'b0);
    send(4'd8, 4'd1, 2'b10, 4'd9, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 4'd1;
    b = 4'd1;
    op = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_txn = 8'd0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_txn_cnt", {24'd0, txn_cnt}, 32'd0);
    check("midrst_out_flags", {26'd0, out, cf, zf}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("no_stale_response", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
